da_idct4: RTL and testbench
===========================

DA_IDCT4 -- requirements
Module: da_idct4

Interface
REQ-001 SHALL have port: sys_clk  input  1  clock; all logic on rising edge.
REQ-002 SHALL have port: sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: Y0..Y3  input  12 each  signed 4-point DCT coefficients, two's complement.
REQ-004 SHALL have port: in_valid  input  1  Y0..Y3 valid this cycle.
REQ-005 SHALL have port: in_ready  output  1  block can accept; combinational, high only in IDLE.
REQ-006 SHALL have ports: x0..x3  output  12 each  signed reconstructed samples, registered.
REQ-007 SHALL have port: out_valid  output  1  x0..x3 valid; one-cycle pulse, registered.

Function
REQ-008 SHALL compute x_n = round(sum_k C[k][n]*Y_k / 1024) as a 4-point inverse DCT, bit-serial distributed arithmetic, Q10 coefficients.
REQ-009 SHALL use coefficient rows: k0 = 512,512,512,512; k1 = 669,277,-277,-669; k2 = 512,-512,-512,512; k3 = 277,-669,669,-277.
REQ-010 SHALL hold four internal combinational 16-entry LUTs, one per output n.
- Address = {Y0[b],Y1[b],Y2[b],Y3[b]}, Y0 bit as MSB.
- Entry = sum of C[k][n] over the set address bits; stored as 12-bit signed; address 0 gives 0.
REQ-011 SHALL implement FSM states IDLE, CALC, OUT; reset state IDLE.
REQ-012 In IDLE, when in_valid=1 (accept edge E0), SHALL capture Y0..Y3, clear the four accumulators, set bit_cnt=11, and go to CALC.
REQ-013 In CALC, each edge SHALL update acc_n <= (acc_n<<1) + s*LUT_n(bit bit_cnt), with s=-1 for bit 11 (sign) and s=+1 otherwise, then decrement bit_cnt.
REQ-014 CALC SHALL last exactly 12 edges (E1..E12, bits 11 down to 0), then go to OUT.
REQ-015 Accumulators SHALL be 24-bit signed; no overflow is permitted (|acc| <= 1970*2048).
REQ-016 In OUT (edge E13), for each n the block SHALL:
- load x_n = sat12((acc_n + 512) >>> 10), arithmetic shift;
- set out_valid=1;
- go to IDLE.
REQ-017 sat12 SHALL clamp to the range [-2048, 2047].
REQ-018 Latency SHALL be fixed: out_valid is high during the cycle following E13, i.e. 13 edges after the accept edge.
REQ-019 out_valid SHALL stay high for exactly one cycle. In every cycle with out_valid=0, x0..x3 SHALL read 0.
REQ-020 There is no output backpressure; results are presented once and not held.
REQ-021 in_valid while in CALC or OUT SHALL be ignored: captured data unchanged, no queuing.
REQ-022 The earliest next accept SHALL be E14, giving a throughput of one block per 14 cycles.
REQ-023 Captured Y registers SHALL remain stable from E0 until OUT completes, regardless of input port changes.

Reset
REQ-024 While sys_rst_n=0, the block SHALL set:
- state=IDLE, in_ready=1;
- out_valid=0, x0..x3=0;
- accumulators, bit_cnt and Y registers to 0.
REQ-025 Reset asserted mid-CALC or mid-OUT SHALL abort the computation. No out_valid SHALL follow the reset release until a new accept.

Verification
REQ-026 DC only: Y0=1024, Y1=Y2=Y3=0 -> one out_valid pulse 13 edges after accept, with x0=x1=x2=x3=512.
REQ-027 Single AC: Y1=1000, others 0 -> x0=653, x1=271, x2=-271, x3=-653.
REQ-028 Negative/rounding: Y0=-2048, others 0 -> all x_n=-1024.
REQ-029 Saturation: Y0=Y1=Y2=Y3=2047 -> x0=2047 (saturated), x1=-784, x2=784, x3=156.
REQ-030 Busy ignore:
- Stimulus: accept Y0=1024; during CALC drive in_valid=1 with Y0=-2048.
- Response: in_ready=0 throughout CALC/OUT; outputs all 512; exactly one out_valid pulse; next accept possible at E14.
REQ-031 Reset mid-operation:
- Stimulus: accept a block, assert sys_rst_n=0 at E5, release two cycles later.
- Response: out_valid stays 0, x_n stay 0, in_ready=1; a fresh DC block afterwards yields 512s.

Source files
------------

// File: rtl/da_idct4.sv
// 4-point inverse DCT using bit-serial distributed arithmetic.
// Each accepted block of four signed 12-bit coefficients is processed one bit
// plane per cycle (MSB first) through four constant 16-entry LUTs. The result
// is rounded, saturated and presented for a single cycle, 13 edges after the
// accept edge. One block can be accepted every 14 cycles.
module da_idct4 (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [11:0] Y0,
   input  logic [11:0] Y1,
   input  logic [11:0] Y2,
   input  logic [11:0] Y3,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [11:0] x0,
   output logic [11:0] x1,
   output logic [11:0] x2,
   output logic [11:0] x3,
   output logic        out_valid
);

   typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

   // Q10 basis: COEF[k][n] weights coefficient Y_k into sample x_n.
   localparam logic signed [11:0] COEF [4][4] = '{
      '{ 12'sd512,  12'sd512,  12'sd512,  12'sd512},
      '{ 12'sd669,  12'sd277, -12'sd277, -12'sd669},
      '{ 12'sd512, -12'sd512, -12'sd512,  12'sd512},
      '{ 12'sd277, -12'sd669,  12'sd669, -12'sd277}
   };

   // LUT entry: sum of the column-n weights whose coefficient bit is set.
   // Address bit 3 selects Y0, bit 0 selects Y3. Partial sums never leave
   // the 12-bit signed range for this basis.
   function automatic logic signed [11:0] lut_entry(input logic [1:0] n,
                                                    input logic [3:0] addr);
      logic signed [11:0] sum;
      sum = '0;
      for (int k = 0; k < 4; k++) begin
         if (addr[3-k]) sum = sum + COEF[k][n];
      end
      return sum;
   endfunction

   // Round to nearest (ties toward +inf) by adding half an LSB before the
   // arithmetic shift, then clamp to the 12-bit output range.
   function automatic logic [11:0] round_sat(input logic signed [23:0] v);
      logic signed [23:0] r;
      r = (v + 24'sd512) >>> 10;
      if (r > 24'sd2047)       return 12'h7ff;
      else if (r < -24'sd2048) return 12'h800;
      else                     return r[11:0];
   endfunction

   state_t             state;
   state_t             state_nxt;
   logic [11:0]        y_q [4];
   logic signed [23:0] acc [4];
   logic [3:0]         bit_cnt;
   logic [11:0]        x_q [4];
   logic [3:0]         lut_addr;
   logic signed [11:0] lut_tab [4][16];
   logic signed [23:0] lut_ext [4];

   assign in_ready = (state == IDLE);
   assign x0 = x_q[0];
   assign x1 = x_q[1];
   assign x2 = x_q[2];
   assign x3 = x_q[3];

   // State register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_nxt;
   end

   // Next-state logic: accept -> 12 bit-plane steps -> output -> idle.
   always_comb begin
      // NOTE: the default assignment up front keeps this block free of
      // inferred latches when a branch leaves the state unchanged.
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = CALC;
         CALC:    if (bit_cnt == 4'd0) state_nxt = OUT;
         OUT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Four constant LUTs, addressed by the current bit plane of the captured
   // coefficients, sign-extended to accumulator width.
   always_comb begin
      lut_addr = {y_q[0][bit_cnt], y_q[1][bit_cnt], y_q[2][bit_cnt], y_q[3][bit_cnt]};
      for (int n = 0; n < 4; n++) begin
         for (int a = 0; a < 16; a++) begin
            lut_tab[n][a] = lut_entry(2'(n), 4'(a));
         end
         lut_ext[n] = {{12{lut_tab[n][lut_addr][11]}}, lut_tab[n][lut_addr]};
      end
   end

   // Datapath: capture, shift-accumulate per bit plane, round/saturate out.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         // NOTE: the captured-coefficient and accumulator arrays are reset
         // too, so an aborted block leaves no stale data behind.
         for (int n = 0; n < 4; n++) begin
            y_q[n] <= '0;
            acc[n] <= '0;
            x_q[n] <= '0;
         end
         bit_cnt   <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         for (int n = 0; n < 4; n++) x_q[n] <= '0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  y_q[0]  <= Y0;
                  y_q[1]  <= Y1;
                  y_q[2]  <= Y2;
                  y_q[3]  <= Y3;
                  bit_cnt <= 4'd11;
                  for (int n = 0; n < 4; n++) acc[n] <= '0;
               end
            end
            CALC: begin
               // Bit 11 is the two's-complement sign plane, so it subtracts.
               for (int n = 0; n < 4; n++) begin
                  if (bit_cnt == 4'd11) acc[n] <= (acc[n] <<< 1) - lut_ext[n];
                  else                  acc[n] <= (acc[n] <<< 1) + lut_ext[n];
               end
               if (bit_cnt != 4'd0) bit_cnt <= bit_cnt - 4'd1;
            end
            OUT: begin
               for (int n = 0; n < 4; n++) x_q[n] <= round_sat(acc[n]);
               out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_da_idct4.sv
// Bench for da_idct4: directed known-answer blocks, busy/ignore, mid-run
// reset and randomized blocks. Expected results are queued at issue time and
// a monitor compares them whenever the DUT presents a result.
module tb_da_idct4;

   logic               sys_clk = 1'b0;
   logic               sys_rst_n = 1'b0;
   logic signed [11:0] Y0, Y1, Y2, Y3;
   logic               in_valid;
   logic               in_ready;
   logic signed [11:0] x0, x1, x2, x3;
   logic               out_valid;

   da_idct4 dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .Y0        (Y0),
      .Y1        (Y1),
      .Y2        (Y2),
      .Y3        (Y3),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x0        (x0),
      .x1        (x1),
      .x2        (x2),
      .x3        (x3),
      .out_valid (out_valid)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int e0;
      int e1;
      int e2;
      int e3;
      int due;
   } exp_t;

   exp_t sb[$];

   localparam int C [4][4] = '{
      '{512,  512,  512,  512},
      '{669,  277, -277, -669},
      '{512, -512, -512,  512},
      '{277, -669,  669, -277}
   };

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: direct matrix product, round half up, clamp to 12 bits.
   function automatic int model(input int n, input int y0, input int y1,
                                input int y2, input int y3);
      int s, t, q;
      s = C[0][n] * y0 + C[1][n] * y1 + C[2][n] * y2 + C[3][n] * y3;
      t = s + 512;
      q = t / 1024;
      if (t < 0 && (t % 1024) != 0) q = q - 1;
      if (q > 2047)  q = 2047;
      if (q < -2048) q = -2048;
      return q;
   endfunction

   // Monitor: every negedge, either consume one expected result or confirm
   // the outputs are quiet.
   initial begin
      exp_t e;
      forever begin
         @(negedge sys_clk);
         if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               check("spurious_out_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               check("latency", cyc, e.due);
               check("x0", int'(x0), e.e0);
               check("x1", int'(x1), e.e1);
               check("x2", int'(x2), e.e2);
               check("x3", int'(x3), e.e3);
            end
         end else begin
            check("x_zero_when_not_valid", int'({x0, x1, x2, x3} != 48'd0), 0);
            if (sb.size() != 0 && sb[0].due <= cyc) begin
               check("missing_out_valid", 0, 1);
               void'(sb.pop_front());
            end
         end
      end
   end

   // Present one block at a negedge; it is accepted at the next posedge.
   // Returns at the following negedge with in_valid dropped.
   task automatic issue(input logic signed [11:0] a, input logic signed [11:0] b,
                        input logic signed [11:0] c, input logic signed [11:0] d,
                        input bit push, input int e0, input int e1,
                        input int e2, input int e3);
      int wait_n;
      exp_t e;
      wait_n = 0;
      while (in_ready !== 1'b1) begin
         @(negedge sys_clk);
         wait_n++;
         if (wait_n > 40) begin
            check("in_ready_timeout", 0, 1);
            return;
         end
      end
      Y0 = a; Y1 = b; Y2 = c; Y3 = d;
      in_valid = 1'b1;
      if (push) begin
         e.e0 = e0; e.e1 = e1; e.e2 = e2; e.e3 = e3;
         e.due = cyc + 14;
         sb.push_back(e);
      end
      @(negedge sys_clk);
      in_valid = 1'b0;
   endtask

   task automatic issue_model(input logic signed [11:0] a, input logic signed [11:0] b,
                              input logic signed [11:0] c, input logic signed [11:0] d);
      issue(a, b, c, d, 1'b1, model(0, a, b, c, d), model(1, a, b, c, d),
            model(2, a, b, c, d), model(3, a, b, c, d));
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge sys_clk);
         n++;
      end
      if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      logic signed [11:0] ra, rb, rc, rd;
      in_valid = 1'b0;
      Y0 = '0; Y1 = '0; Y2 = '0; Y3 = '0;

      // Reset state.
      repeat (3) @(negedge sys_clk);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_x0", int'(x0), 0);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);

      // Known-answer blocks.
      issue(12'sd1024, 12'sd0, 12'sd0, 12'sd0, 1'b1, 512, 512, 512, 512);
      wait_drain();
      issue(12'sd0, 12'sd1000, 12'sd0, 12'sd0, 1'b1, 653, 271, -271, -653);
      wait_drain();
      issue(-12'sd2048, 12'sd0, 12'sd0, 12'sd0, 1'b1, -1024, -1024, -1024, -1024);
      wait_drain();
      issue(12'sd2047, 12'sd2047, 12'sd2047, 12'sd2047, 1'b1, 2047, -784, 784, 156);
      wait_drain();

      // Busy ignore: hold a new block on the inputs for the whole run.
      issue(12'sd1024, 12'sd0, 12'sd0, 12'sd0, 1'b1, 512, 512, 512, 512);
      Y0 = -12'sd2048;
      in_valid = 1'b1;
      for (int i = 0; i < 13; i++) begin
         check("in_ready_busy", int'(in_ready), 0);
         @(negedge sys_clk);
      end
      check("in_ready_at_e14", int'(in_ready), 1);
      e.e0 = -1024; e.e1 = -1024; e.e2 = -1024; e.e3 = -1024;
      e.due = cyc + 14;
      sb.push_back(e);
      @(negedge sys_clk);
      in_valid = 1'b0;
      Y0 = '0;
      wait_drain();

      // Reset mid-CALC: the aborted block must never produce a result.
      issue(12'sd1000, -12'sd500, 12'sd300, 12'sd7, 1'b0, 0, 0, 0, 0);
      repeat (4) @(negedge sys_clk);
      @(posedge sys_clk);
      #1 sys_rst_n = 1'b0;
      @(negedge sys_clk);
      check("midrst_in_ready", int'(in_ready), 1);
      check("midrst_out_valid", int'(out_valid), 0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge sys_clk);
         check("post_rst_in_ready", int'(in_ready), 1);
      end
      issue(12'sd1024, 12'sd0, 12'sd0, 12'sd0, 1'b1, 512, 512, 512, 512);
      wait_drain();

      // Randomized blocks with random idle gaps, including back-to-back.
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge sys_clk);
         ra = 12'($urandom_range(0, 4095));
         rb = 12'($urandom_range(0, 4095));
         rc = 12'($urandom_range(0, 4095));
         rd = 12'($urandom_range(0, 4095));
         issue_model(ra, rb, rc, rd);
      end
      wait_drain();
      repeat (4) @(negedge sys_clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
